// File: rtl/multiplier_arbiter_pkg.sv
// rtl/multiplier_arbiter_pkg.sv - shared types, defaults and round-robin pick for multiplier_arbiter
package multiplier_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;
  localparam int MAX_REQ     = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} arb_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit searching last+1, last+2, ... modulo num_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0] last,
                                       input int num_req);
    rr_pick_t pick;
    int       idx;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= num_req && !pick.valid) begin
        idx = (int'(last) + k) % num_req;
        if (req[idx]) begin
          pick.valid = 1'b1;
          pick.idx   = 3'(idx);
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/multiplier_arbiter_if.sv
// rtl/multiplier_arbiter_if.sv - requester and multiplier signals of multiplier_arbiter
interface multiplier_arbiter_if
  import multiplier_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [2*WIDTH-1:0]       result;
  logic                     mult_start;
  logic [WIDTH-1:0]         mult_a;
  logic [WIDTH-1:0]         mult_b;
  logic                     mult_ready;
  logic [2*WIDTH-1:0]       mult_product;

  modport master (
    input  req, req_a, req_b, mult_ready, mult_product,
    output grant, done, result, mult_start, mult_a, mult_b
  );

  modport slave (
    output req, req_a, req_b, mult_ready, mult_product,
    input  grant, done, result, mult_start, mult_a, mult_b
  );
endinterface

// File: rtl/multiplier_arbiter_rr.sv
// rtl/multiplier_arbiter_rr.sv - round-robin pick with registered last-winner pointer
module rr_arbiter
  import multiplier_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [2:0]         winner,
  output logic               valid
);
  logic [2:0]         last;
  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick                   = rr_pick(req_ext, last, NUM_REQ);
  end

  assign winner = pick.idx;
  assign valid  = pick.valid;

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= 3'(NUM_REQ - 1);
    end else if (accept && pick.valid) begin
      last <= pick.idx;
    end
  end
endmodule

// File: rtl/multiplier_arbiter.sv
// rtl/multiplier_arbiter.sv - shares one sequential multiplier among requesters; MULT_ARB_TIMEOUT_EN adds a WAIT watchdog
module multiplier_arbiter
  import multiplier_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  multiplier_arbiter_if.master bus
`ifdef MULT_ARB_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);
  arb_state_t         state, state_next;
  logic [2:0]         winner_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] result_q;
  logic [2:0]         pick_idx;
  logic               pick_valid;
  logic               accept;
  logic               wd_expired;

  assign accept = (state == IDLE) && pick_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clock  (clock),
    .reset  (reset),
    .req    (bus.req),
    .accept (accept),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Counter sits at zero outside WAIT, so it is clear on every WAIT entry.
  assign wd_expired = (state == WAIT) && !bus.mult_ready &&
                      (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= wd_expired;
      wd_cnt  <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (bus.mult_ready)  state_next = RESPOND;
        else if (wd_expired) state_next = IDLE;
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      winner_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        winner_q <= pick_idx;
        a_q      <= bus.req_a[int'(pick_idx)*WIDTH +: WIDTH];
        b_q      <= bus.req_b[int'(pick_idx)*WIDTH +: WIDTH];
      end
      if (state == WAIT && bus.mult_ready) begin
        result_q <= bus.mult_product;
      end
    end
  end

  assign bus.mult_start = (state == ISSUE);
  assign bus.grant      = (state == ISSUE)   ? (NUM_REQ'(1) << winner_q) : '0;
  assign bus.done       = (state == RESPOND) ? (NUM_REQ'(1) << winner_q) : '0;
  assign bus.mult_a     = a_q;
  assign bus.mult_b     = b_q;
  assign bus.result     = result_q;
endmodule
